// File: rtl/sdram_write.sv
// Page-burst write engine: ACTIVE, WRITE, stream data, BURST STOP,
// PRECHARGE, tRP wait, then a one-cycle wr_end pulse.
//
// Ports:
//   sys_clk, sys_rst     clock, async active-high reset
//   init_end             SDRAM init done (gates new bursts only)
//   wr_en                level request from the arbiter
//   wr_addr              {bank[1:0], row[12:0], col[8:0]}
//   wr_data              FWFT FIFO word, consumed while wr_ack=1
//   wr_burst_len         words per burst (0 -> 1, >512 -> 512)
//   wr_ack               FIFO read strobe
//   wr_end               burst fully closed
//   write_cmd            {CS_n,RAS_n,CAS_n,WE_n}
//   write_ba/write_addr  bank / A[12:0]
//   wr_sdram_en          DQ output enable
//   wr_sdram_data        DQ drive data
//
// Option: define SDRAM_WR_BANK_PRE_EN to precharge only the written
// bank instead of precharging all banks.
//
// A start column plus length beyond 511 wraps inside the open row
// (SDRAM full-page behaviour); the burst is never split.

module sdram_write #(
  parameter int TRCD_CLK = 2,
  parameter int TRP_CLK  = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        init_end,
  input  logic        wr_en,
  input  logic [23:0] wr_addr,
  input  logic [15:0] wr_data,
  input  logic [9:0]  wr_burst_len,
  output logic        wr_ack,
  output logic        wr_end,
  output logic [3:0]  write_cmd,
  output logic [1:0]  write_ba,
  output logic [12:0] write_addr,
  output logic        wr_sdram_en,
  output logic [15:0] wr_sdram_data
);

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_BST = 4'b0110;
  localparam logic [3:0] CMD_PRE = 4'b0010;

  localparam logic [9:0] TRCD_LAST = 10'(TRCD_CLK - 1);
  localparam logic [9:0] TRP_LAST  = 10'(TRP_CLK - 1);

  typedef enum logic [3:0] {
    WR_IDLE,
    WR_ACTIVE,
    WR_TRCD,
    WR_WRITE,
    WR_DATA,
    WR_BSTOP,
    WR_PRE,
    WR_TRP,
    WR_END
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [9:0]  cnt_clk;
  logic [1:0]  bank_q;
  logic [12:0] row_q;
  logic [8:0]  col_q;
  logic [9:0]  len_q;
  logic        start;

  assign start = (state == WR_IDLE) && init_end && wr_en;

  function automatic logic [9:0] clamp_len(input logic [9:0] l);
    if (l == 10'd0)
      return 10'd1;
    else if (l > 10'd512)
      return 10'd512;
    else
      return l;
  endfunction

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state   <= WR_IDLE;
      cnt_clk <= 10'd0;
      bank_q  <= 2'd0;
      row_q   <= 13'd0;
      col_q   <= 9'd0;
      len_q   <= 10'd1;
    end else begin
      state <= state_nxt;
      // Saturate so long idle stretches never wrap the counter.
      if (state_nxt != state)
        cnt_clk <= 10'd0;
      else if (cnt_clk != 10'h3FF)
        cnt_clk <= cnt_clk + 10'd1;
      if (start) begin
        bank_q <= wr_addr[23:22];
        row_q  <= wr_addr[21:9];
        col_q  <= wr_addr[8:0];
        len_q  <= clamp_len(wr_burst_len);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      WR_IDLE:   if (start) state_nxt = WR_ACTIVE;
      WR_ACTIVE: state_nxt = WR_TRCD;
      WR_TRCD:   if (cnt_clk == TRCD_LAST) state_nxt = WR_WRITE;
      WR_WRITE:  state_nxt = (len_q == 10'd1) ? WR_BSTOP : WR_DATA;
      // WRITE carried word 0, so DATA lasts len-1 cycles.
      WR_DATA:   if (cnt_clk == len_q - 10'd2) state_nxt = WR_BSTOP;
      WR_BSTOP:  state_nxt = WR_PRE;
      WR_PRE:    state_nxt = WR_TRP;
      WR_TRP:    if (cnt_clk == TRP_LAST) state_nxt = WR_END;
      WR_END:    state_nxt = WR_IDLE;
      default:   state_nxt = WR_IDLE;
    endcase
  end

  always_comb begin
    write_cmd  = CMD_NOP;
    write_ba   = 2'b11;
    write_addr = 13'h1FFF;
    wr_ack     = 1'b0;
    wr_end     = 1'b0;
    unique case (state)
      WR_ACTIVE: begin
        write_cmd  = CMD_ACT;
        write_ba   = bank_q;
        write_addr = row_q;
      end
      WR_WRITE: begin
        write_cmd  = CMD_WR;
        write_ba   = bank_q;
        write_addr = {4'b0000, col_q};
        wr_ack     = 1'b1;
      end
      WR_DATA: wr_ack = 1'b1;
      WR_BSTOP: write_cmd = CMD_BST;
      WR_PRE: begin
        write_cmd = CMD_PRE;
`ifdef SDRAM_WR_BANK_PRE_EN
        write_ba   = bank_q;
        write_addr = 13'h0000;
`else
        write_ba   = 2'b11;
        write_addr = 13'h0400;
`endif
      end
      WR_END: wr_end = 1'b1;
      default: ;
    endcase
  end

  assign wr_sdram_en   = wr_ack;
  assign wr_sdram_data = wr_ack ? wr_data : 16'h0000;

endmodule

// File: tb/tb_sdram_write.sv
// Testbench for sdram_write: table-driven basic burst plus
// directed sequences for length limits, init gating and reset.

module tb_sdram_write;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] ACT = 4'b0011;
  localparam logic [3:0] WR  = 4'b0100;
  localparam logic [3:0] BST = 4'b0110;
  localparam logic [3:0] PRE = 4'b0010;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        init_end = 1'b0;
  logic        wr_en = 1'b0;
  logic [23:0] wr_addr = 24'd0;
  logic [15:0] wr_data;
  logic [9:0]  wr_burst_len = 10'd1;
  logic        wr_ack;
  logic        wr_end;
  logic [3:0]  write_cmd;
  logic [1:0]  write_ba;
  logic [12:0] write_addr;
  logic        wr_sdram_en;
  logic [15:0] wr_sdram_data;

  sdram_write #(.TRCD_CLK(2), .TRP_CLK(2)) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .init_end(init_end),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_burst_len(wr_burst_len),
    .wr_ack(wr_ack),
    .wr_end(wr_end),
    .write_cmd(write_cmd),
    .write_ba(write_ba),
    .write_addr(write_addr),
    .wr_sdram_en(wr_sdram_en),
    .wr_sdram_data(wr_sdram_data)
  );

  always #5 sys_clk = ~sys_clk;

  // FWFT FIFO model: word index advances on each acked edge.
  int ack_total = 0;
  int ack_base = 0;
  always @(posedge sys_clk)
    if (wr_ack) ack_total <= ack_total + 1;
  assign wr_data = 16'hD000 + 16'(ack_total - ack_base);

  int pass_cnt = 0;
  int total = 0;

  // Packed output bundle: cmd,ba,addr,ack,end,en,data (38 bits).
  logic [37:0] outs;
  assign outs = {write_cmd, write_ba, write_addr, wr_ack,
                 wr_end, wr_sdram_en, wr_sdram_data};

  localparam logic [37:0] M_ALL = {38{1'b1}};
  localparam logic [37:0] M_NBA = ~({2'b11, 13'h1FFF} << 19);
  localparam logic [37:0] M_PRE = M_ALL & ~(38'h1FFF << 19)
                                  | (38'h1 << 29);
  localparam logic [37:0] RST_V =
    {NOP, 2'b11, 13'h1FFF, 1'b0, 1'b0, 1'b0, 16'h0};

  typedef struct {
    int          cyc;
    logic [37:0] exp;
    logic [37:0] mask;
  } vec_t;

  function automatic logic [37:0] v(
    input logic [3:0] c, input logic [1:0] b,
    input logic [12:0] a, input logic ack,
    input logic e, input logic [15:0] d);
    return {c, b, a, ack, e, ack, d};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Pulse wr_en for one cycle and watch the burst to wr_end.
  task automatic run_burst(input logic [23:0] a, input logic [9:0] l,
                           output int acks, output int wcyc,
                           output int bcyc, output int ecyc,
                           output int dbad, output int pcyc,
                           output logic [1:0] pba,
                           output logic pa10);
    acks = 0; wcyc = -1; bcyc = -1; ecyc = -1; dbad = 0;
    pcyc = -1; pba = 2'b00; pa10 = 1'b0;
    @(posedge sys_clk); #1;
    wr_addr = a; wr_burst_len = l; wr_en = 1'b1;
    for (int c = 1; c < 800; c++) begin
      @(posedge sys_clk); #1;
      wr_en = 1'b0;
      @(negedge sys_clk);
      if (wr_ack) acks++;
      if (wr_sdram_en !== wr_ack) dbad++;
      if (wr_sdram_data !== (wr_ack ? wr_data : 16'h0)) dbad++;
      if (write_cmd == WR) wcyc = c;
      if (write_cmd == BST) bcyc = c;
      if (write_cmd == PRE) begin
        pcyc = c; pba = write_ba; pa10 = write_addr[10];
      end
      if (wr_end) begin
        ecyc = c;
        break;
      end
    end
    if (ecyc < 0) $display("FAIL timeout: no wr_end");
  endtask

  task automatic burst_chk(input string nm, input logic [23:0] a,
                           input logic [9:0] l, input int el);
    int acks, wc, bc, ec, db, pc;
    logic [1:0] pb;
    logic pa;
    run_burst(a, l, acks, wc, bc, ec, db, pc, pb, pa);
    chk({nm, "_acks"}, 64'(acks), 64'(el));
    chk({nm, "_bstop"}, 64'(bc - wc), 64'(el));
    chk({nm, "_end"}, 64'(ec - bc), 64'd4);
    chk({nm, "_dq"}, 64'(db), 64'd0);
  endtask

  vec_t tbl[13];

  initial begin
    int bad;
    int acks, wc, bc, ec, db, pc;
    logic [1:0] pb;
    logic pa;

    // Basic burst, wr_en at cycle t, addr 40_0203, len 4.
    tbl[0]  = '{1,  v(ACT, 2'd1, 13'h0001, 0, 0, 16'h0), M_ALL};
    tbl[1]  = '{2,  RST_V, M_ALL};
    tbl[2]  = '{3,  RST_V, M_ALL};
    tbl[3]  = '{4,  v(WR, 2'd1, 13'h0003, 1, 0, 16'hD000), M_ALL};
    tbl[4]  = '{5,  v(NOP, 2'd3, 13'h0, 1, 0, 16'hD001), M_NBA};
    tbl[5]  = '{6,  v(NOP, 2'd3, 13'h0, 1, 0, 16'hD002), M_NBA};
    tbl[6]  = '{7,  v(NOP, 2'd3, 13'h0, 1, 0, 16'hD003), M_NBA};
    tbl[7]  = '{8,  v(BST, 2'd3, 13'h0, 0, 0, 16'h0), M_NBA};
    tbl[8]  = '{9,  v(PRE, 2'd3, 13'h0400, 0, 0, 16'h0), M_PRE};
    tbl[9]  = '{10, v(NOP, 2'd3, 13'h0, 0, 0, 16'h0), M_NBA};
    tbl[10] = '{11, v(NOP, 2'd3, 13'h0, 0, 0, 16'h0), M_NBA};
    tbl[11] = '{12, v(NOP, 2'd3, 13'h0, 0, 1, 16'h0), M_NBA};
    tbl[12] = '{13, RST_V, M_ALL};

    #12;
    chk("reset_outputs", 64'(outs), 64'(RST_V));
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    init_end = 1'b1;

    @(posedge sys_clk); #1;
    ack_base = ack_total;
    wr_addr = 24'h40_0203; wr_burst_len = 10'd4; wr_en = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(posedge sys_clk); #1;
      wr_en = 1'b0;
      @(negedge sys_clk);
      chk($sformatf("basic_t+%0d", tbl[i].cyc),
          64'(outs & tbl[i].mask),
          64'(tbl[i].exp & tbl[i].mask));
    end

    burst_chk("len1", 24'h00_0010, 10'd1, 1);
    burst_chk("len0", 24'h00_0010, 10'd0, 1);
    burst_chk("len2", 24'h00_0100, 10'd2, 2);
    burst_chk("len512", 24'h00_0000, 10'd512, 512);
    burst_chk("len700", 24'h00_0000, 10'd700, 512);
    burst_chk("wrap", 24'h00_01FF, 10'd4, 4);

    // Precharge addressing for a bank-2 burst.
    run_burst(24'h80_0000, 10'd3, acks, wc, bc, ec, db, pc, pb, pa);
    chk("pre_cycle", 64'(pc - bc), 64'd1);
`ifdef SDRAM_WR_BANK_PRE_EN
    chk("pre_bank", {61'd0, pb, pa}, {61'd0, 2'b10, 1'b0});
`else
    chk("pre_bank", {61'd0, pb, pa}, {61'd0, 2'b11, 1'b1});
`endif

    // init_end low blocks requests.
    @(posedge sys_clk); #1;
    init_end = 1'b0; wr_en = 1'b1; wr_burst_len = 10'd2;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      if (write_cmd !== NOP || wr_ack !== 1'b0) bad++;
      @(posedge sys_clk); #1;
    end
    chk("init_block", 64'(bad), 64'd0);
    init_end = 1'b1;
    @(posedge sys_clk); #1;
    @(negedge sys_clk);
    chk("init_release_act", 64'(write_cmd), 64'(ACT));

    // wr_en held: IDLE cycle between wr_end and next ACTIVE.
    bad = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge sys_clk);
      if (wr_end) begin
        bad = 0;
        break;
      end
    end
    chk("held_end_seen", 64'(bad), 64'd0);
    @(negedge sys_clk);
    chk("held_idle_gap", 64'(write_cmd), 64'(NOP));
    @(negedge sys_clk);
    chk("held_next_act", 64'(write_cmd), 64'(ACT));
    @(posedge sys_clk); #1;
    wr_en = 1'b0;

    // Reset during the third data word of an 8-word burst.
    for (int i = 0; i < 40; i++) begin
      @(negedge sys_clk);
      if (wr_end) break;
    end
    @(posedge sys_clk); #1;
    wr_burst_len = 10'd8; wr_en = 1'b1;
    @(posedge sys_clk); #1;
    wr_en = 1'b0;
    acks = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge sys_clk);
      if (wr_ack) acks++;
      if (acks == 3) break;
    end
    chk("rst_mid_ackcnt", 64'(acks), 64'd3);
    #1 sys_rst = 1'b1;
    #1 chk("rst_async_out", 64'(outs), 64'(RST_V));
    @(posedge sys_clk); #1;
    sys_rst = 1'b0; wr_en = 1'b1;
    @(posedge sys_clk); #1;
    wr_en = 1'b0;
    @(negedge sys_clk);
    chk("rst_fresh_act", 64'(write_cmd), 64'(ACT));
    for (int i = 0; i < 40; i++) begin
      @(negedge sys_clk);
      if (wr_end) break;
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/sdram_write.md
Name: sdram_write

Overview:
- Page-burst write engine for the SDRAM controller; the write-direction counterpart of the page-burst read path.
- Sits between the controller arbiter (wr_en/wr_end) and the SDRAM command/data mux.
- Opens a row, issues one WRITE command, and streams wr_burst_len 16-bit words from an upstream FIFO.
- Terminates with BURST STOP, precharges, waits tRP, and pulses wr_end.

Parameters:
- TRCD_CLK, 2: NOP cycles between ACTIVE and WRITE.
- TRP_CLK, 2: NOP cycles after PRECHARGE before END.

Ports:
- sys_clk  input  1  controller clock.
- sys_rst  input  1  reset; asynchronous, active-high.
- init_end  input  1  SDRAM init complete; writes are blocked while low.
- wr_en  input  1  write request from arbiter; level-sensitive.
- wr_addr  input  24  [23:22] bank, [21:9] row, [8:0] start column.
- wr_data  input  16  upstream FIFO data, valid in any cycle where wr_ack=1.
- wr_burst_len  input  10  words per burst; valid range 1..512.
- wr_ack  output  1  FIFO read strobe; high for exactly the burst-length cycles.
- wr_end  output  1  one-cycle pulse when the burst is fully closed.
- write_cmd  output  4  {CS_n,RAS_n,CAS_n,WE_n}.
- write_ba  output  2  bank address.
- write_addr  output  13  SDRAM A[12:0].
- wr_sdram_en  output  1  DQ output-enable.
- wr_sdram_data  output  16  DQ drive data.

Behaviour:
- Command encodings: NOP 0111, ACTIVE 0011, WRITE 0100, B_STOP 0110, P_CHARGE 0010.
- Reset (async, sys_rst=1):
  - State goes to WR_IDLE immediately, including mid-burst; the burst is abandoned.
  - Outputs: write_cmd=NOP, write_ba=2'b11, write_addr=13'h1FFF, wr_ack=0, wr_end=0, wr_sdram_en=0, wr_sdram_data=0.
- States: WR_IDLE, WR_ACTIVE, WR_TRCD, WR_WRITE, WR_DATA, WR_BSTOP, WR_PRE, WR_TRP, WR_END.
- Counter: 10-bit cnt_clk, cleared on every state entry, increments otherwise.
- Command/address outputs are a Moore decode of the state register. Each command therefore appears in the cycle the state is occupied.
- WR_IDLE:
  - Exit to WR_ACTIVE when init_end=1 && wr_en=1, sampled at the clock edge.
  - On that same edge, latch wr_addr and wr_burst_len.
  - A latched length of 0 is forced to 1; values above 512 are clamped to 512.
- WR_ACTIVE (1 cycle): cmd=ACTIVE, ba=latched bank, addr=latched row.
- WR_TRCD (TRCD_CLK cycles): cmd=NOP, ba/addr = reset values.
- WR_WRITE (1 cycle):
  - cmd=WRITE, ba=bank, addr={4'b0000, column}.
  - wr_ack=1; the first word is on DQ.
- WR_DATA (len-1 cycles; skipped when len=1): cmd=NOP, wr_ack=1.
- WR_BSTOP (1 cycle): cmd=B_STOP, wr_ack=0, wr_sdram_en=0.
- WR_PRE (1 cycle): cmd=P_CHARGE, addr[10]=1 (all banks), ba=2'b11.
- WR_TRP (TRP_CLK cycles): cmd=NOP.
- WR_END (1 cycle): cmd=NOP, wr_end=1; next state is WR_IDLE.
- After WR_END, at least one WR_IDLE cycle always precedes a new ACTIVE, even if wr_en is held high.
- Data path (combinational, no added latency):
  - wr_sdram_en=wr_ack.
  - wr_sdram_data = wr_ack ? wr_data : 16'h0000.
  - The upstream FIFO must be first-word-fall-through.
- Column wrap: a start column plus len beyond 511 wraps within the same row (SDRAM page behaviour). The block does not split the burst; this is documented, not flagged.
- wr_en, wr_addr and wr_burst_len changes outside WR_IDLE are ignored.
- init_end falling mid-burst is ignored; the burst completes.

Optional Feature:
- Macro: SDRAM_WR_BANK_PRE_EN.
- Defined: WR_PRE precharges only the written bank (addr[10]=0, ba=latched bank); all other cycles are unchanged.
- Undefined: precharge-all (addr[10]=1, ba=2'b11).

Test Plan:
- Basic burst (TRCD_CLK=2, TRP_CLK=2), wr_en at cycle t with addr=24'h40_0203, len=4:
  - Cmds ACTIVE(t+1, ba=1, row=1), NOP×2, WRITE(t+4, addr=0x003).
  - wr_ack high t+4..t+7 with data D0..D3 on DQ.
  - B_STOP t+8, P_CHARGE t+9 (A10=1), NOP×2, wr_end at t+12.
- len=1: WRITE then immediately B_STOP; wr_ack high exactly 1 cycle. len=0: identical to len=1.
- len=512 at column 0: wr_ack high 512 consecutive cycles, then B_STOP; cnt_clk must not overflow.
- init_end=0 with wr_en=1 for 20 cycles: write_cmd stays NOP, no wr_ack. Raising init_end then starts ACTIVE on the next cycle.
- sys_rst asserted mid-WR_DATA (3rd word of 8): all outputs take reset values without waiting for a clock edge. After release with wr_en=1, a fresh ACTIVE is issued.
- With SDRAM_WR_BANK_PRE_EN, bank 2 burst: the P_CHARGE cycle shows addr[10]=0, ba=2'b10. Without it: addr[10]=1, ba=2'b11.
